// File: rtl/neuron_param_store.sv
`default_nettype none
// ============================================================================
// Module   : neuron_param_store
// Purpose  : Izhikevich (a,b,c,d) constant store with two registered read
//            ports, masked writes, write-to-read bypass and an init sweep.
// Revision : 1.0
// ============================================================================
module neuron_param_store #(
    parameter int                  NUMWIDTH   = 16,
    parameter int                  NUMNEURONS = 8,
    parameter int                  TAGBITS    = 3,
    parameter logic [NUMWIDTH-1:0] DEF_A      = 16'h0005,
    parameter logic [NUMWIDTH-1:0] DEF_B      = 16'h0033,
    parameter logic [NUMWIDTH-1:0] DEF_C      = 16'hBF00,
    parameter logic [NUMWIDTH-1:0] DEF_D      = 16'h0800
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_req,
    output logic                    init_busy,
    input  logic                    wr_en,
    input  logic [TAGBITS-1:0]      wr_tag,
    input  logic [3:0]              wr_mask,
    input  logic [4*NUMWIDTH-1:0]   wr_value,
    output logic                    wr_err,
    input  logic                    rd_en_a,
    input  logic [TAGBITS-1:0]      rd_tag_a,
    output logic [4*NUMWIDTH-1:0]   rd_value_a,
    output logic                    rd_valid_a,
    output logic                    rd_err_a,
    input  logic                    rd_en_b,
    input  logic [TAGBITS-1:0]      rd_tag_b,
    output logic [4*NUMWIDTH-1:0]   rd_value_b,
    output logic                    rd_valid_b,
    output logic                    rd_err_b
);

    localparam int                    c_entry_w  = 4 * NUMWIDTH;
    localparam logic [TAGBITS:0]      c_num      = NUMNEURONS[TAGBITS:0];
    localparam logic [TAGBITS-1:0]    c_last     = TAGBITS'(NUMNEURONS - 1);
    localparam logic [c_entry_w-1:0]  c_defaults = {DEF_A, DEF_B, DEF_C, DEF_D};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [TAGBITS-1:0]     ptr_q, ptr_d;
    logic                   wr_err_q, wr_err_d;
    logic [c_entry_w-1:0]   mem_q [NUMNEURONS];
    logic [c_entry_w-1:0]   mem_d [NUMNEURONS];
    logic [c_entry_w-1:0]   wr_old;
    logic [c_entry_w-1:0]   wr_merged;
    logic                   wr_ok;
    logic                   rd_en  [2];
    logic [TAGBITS-1:0]     rd_tag [2];

    function automatic logic in_range(input logic [TAGBITS-1:0] tag);
        return {1'b0, tag} < c_num;
    endfunction

    // Field 0 is d (LSBs), field 3 is a (MSBs); mask bit f selects field f.
    function automatic logic [c_entry_w-1:0] merge_fields(
        input logic [c_entry_w-1:0] old_val,
        input logic [c_entry_w-1:0] new_val,
        input logic [3:0]           mask
    );
        logic [c_entry_w-1:0] res;
        res = old_val;
        for (int f = 0; f < 4; f++) begin
            if (mask[f]) begin
                res[f*NUMWIDTH +: NUMWIDTH] = new_val[f*NUMWIDTH +: NUMWIDTH];
            end
        end
        return res;
    endfunction

    assign rd_en[0]  = rd_en_a;
    assign rd_en[1]  = rd_en_b;
    assign rd_tag[0] = rd_tag_a;
    assign rd_tag[1] = rd_tag_b;

    always_comb begin
        wr_old = '0;
        for (int i = 0; i < NUMNEURONS; i++) begin
            if (wr_tag == TAGBITS'(i)) begin
                wr_old = mem_q[i];
            end
        end
        wr_merged = merge_fields(wr_old, wr_value, wr_mask);
        wr_ok     = wr_en && (state_q == ST_RUN) && !clear_req && in_range(wr_tag);
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        mem_d    = mem_q;
        wr_err_d = wr_en && !wr_ok;
        case (state_q)
            ST_INIT: begin
                for (int i = 0; i < NUMNEURONS; i++) begin
                    if (ptr_q == TAGBITS'(i)) begin
                        mem_d[i] = c_defaults;
                    end
                end
                if (clear_req) begin
                    ptr_d = '0;
                end else if (ptr_q == c_last) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + TAGBITS'(1);
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
                end else if (wr_ok) begin
                    for (int i = 0; i < NUMNEURONS; i++) begin
                        if (wr_tag == TAGBITS'(i)) begin
                            mem_d[i] = wr_merged;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            ptr_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Contents are meaningless until the sweep completes, so no reset here.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic [c_entry_w-1:0] entry;
        logic [c_entry_w-1:0] value_q, value_d;
        logic                 valid_q, valid_d;
        logic                 err_q, err_d;

        always_comb begin
            entry = '0;
            for (int i = 0; i < NUMNEURONS; i++) begin
                if (rd_tag[p] == TAGBITS'(i)) begin
                    entry = mem_q[i];
                end
            end
            value_d = value_q;
            valid_d = 1'b0;
            err_d   = 1'b0;
            if (rd_en[p]) begin
                if (state_q != ST_RUN) begin
                    value_d = '0;
                end else if (!in_range(rd_tag[p])) begin
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    value_d = '0;
                end else begin
                    valid_d = 1'b1;
                    value_d = (wr_ok && (wr_tag == rd_tag[p])) ? wr_merged : entry;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                value_q <= '0;
                valid_q <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                value_q <= value_d;
                valid_q <= valid_d;
                err_q   <= err_d;
            end
        end
    end

    assign init_busy  = (state_q == ST_INIT);
    assign wr_err     = wr_err_q;
    assign rd_value_a = g_rd_port[0].value_q;
    assign rd_valid_a = g_rd_port[0].valid_q;
    assign rd_err_a   = g_rd_port[0].err_q;
    assign rd_value_b = g_rd_port[1].value_q;
    assign rd_valid_b = g_rd_port[1].valid_q;
    assign rd_err_b   = g_rd_port[1].err_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_param_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_param_store
// Purpose  : Directed scoreboard bench for neuron_param_store (8- and 6-entry).
// Revision : 1.0
// ============================================================================
module tb_neuron_param_store;

    localparam logic [63:0] DEFS = 64'h0005_0033_BF00_0800;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clear_req, wr_en, rd_en_a, rd_en_b;
    logic [2:0]  wr_tag, rd_tag_a, rd_tag_b;
    logic [3:0]  wr_mask;
    logic [63:0] wr_value;

    logic        busy8, werr8, rvla8, rea8, rvlb8, reb8;
    logic [63:0] rva8, rvb8;
    logic        busy6, werr6, rvla6, rea6, rvlb6, reb6;
    logic [63:0] rva6, rvb6;

    neuron_param_store #(.NUMNEURONS(8), .TAGBITS(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .init_busy(busy8),
        .wr_en(wr_en), .wr_tag(wr_tag), .wr_mask(wr_mask), .wr_value(wr_value),
        .wr_err(werr8),
        .rd_en_a(rd_en_a), .rd_tag_a(rd_tag_a), .rd_value_a(rva8),
        .rd_valid_a(rvla8), .rd_err_a(rea8),
        .rd_en_b(rd_en_b), .rd_tag_b(rd_tag_b), .rd_value_b(rvb8),
        .rd_valid_b(rvlb8), .rd_err_b(reb8)
    );

    neuron_param_store #(.NUMNEURONS(6), .TAGBITS(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .init_busy(busy6),
        .wr_en(wr_en), .wr_tag(wr_tag), .wr_mask(wr_mask), .wr_value(wr_value),
        .wr_err(werr6),
        .rd_en_a(rd_en_a), .rd_tag_a(rd_tag_a), .rd_value_a(rva6),
        .rd_valid_a(rvla6), .rd_err_a(rea6),
        .rd_en_b(rd_en_b), .rd_tag_b(rd_tag_b), .rd_value_b(rvb6),
        .rd_valid_b(rvlb6), .rd_err_b(reb6)
    );

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [63:0] val;
    } rd_t;

    rd_t         qa8[$], qb8[$], qa6[$], qb6[$];
    logic [63:0] m8 [8];
    logic [63:0] m6 [6];
    bit          run8, run6, chk6, pend_a, pend_b;
    logic        exp_werr8, exp_werr6;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                          input logic [3:0] m);
        logic [63:0] bm;
        bm = {{16{m[3]}}, {16{m[2]}}, {16{m[1]}}, {16{m[0]}}};
        return (o & ~bm) | (n & bm);
    endfunction

    function automatic rd_t exp8(input logic [2:0] t);
        rd_t r;
        r = '0;
        if (run8) begin
            r.valid = 1'b1;
            r.val   = m8[t];
        end
        return r;
    endfunction

    function automatic rd_t exp6(input logic [2:0] t);
        rd_t r;
        r = '0;
        if (run6) begin
            r.valid = 1'b1;
            if (t >= 3'd6) r.err = 1'b1;
            else           r.val = m6[t];
        end
        return r;
    endfunction

    // Set clear_req before calling: a write alongside a clear is rejected.
    task automatic wr(input logic [2:0] t, input logic [3:0] m, input logic [63:0] v);
        wr_en     = 1'b1;
        wr_tag    = t;
        wr_mask   = m;
        wr_value  = v;
        exp_werr8 = !run8 || clear_req;
        if (!exp_werr8) m8[t] = merge(m8[t], v, m);
        exp_werr6 = !run6 || clear_req || (t >= 3'd6);
        if (!exp_werr6) m6[t] = merge(m6[t], v, m);
    endtask

    task automatic rd_a(input logic [2:0] t);
        rd_en_a  = 1'b1;
        rd_tag_a = t;
        qa8.push_back(exp8(t));
        if (chk6) qa6.push_back(exp6(t));
        pend_a = 1'b1;
    endtask

    task automatic rd_b(input logic [2:0] t);
        rd_en_b  = 1'b1;
        rd_tag_b = t;
        qb8.push_back(exp8(t));
        if (chk6) qb6.push_back(exp6(t));
        pend_b = 1'b1;
    endtask

    task automatic tick();
        rd_t e;
        @(posedge clk);
        #1;
        chk("wr_err8", 64'(werr8), 64'(exp_werr8));
        if (chk6) chk("wr_err6", 64'(werr6), 64'(exp_werr6));
        if (pend_a) begin
            e = qa8.pop_front();
            chk("rdA8.valid", 64'(rvla8), 64'(e.valid));
            chk("rdA8.err",   64'(rea8),  64'(e.err));
            chk("rdA8.value", rva8, e.val);
            if (qa6.size() > 0) begin
                e = qa6.pop_front();
                chk("rdA6.valid", 64'(rvla6), 64'(e.valid));
                chk("rdA6.err",   64'(rea6),  64'(e.err));
                chk("rdA6.value", rva6, e.val);
            end
        end
        if (pend_b) begin
            e = qb8.pop_front();
            chk("rdB8.valid", 64'(rvlb8), 64'(e.valid));
            chk("rdB8.err",   64'(reb8),  64'(e.err));
            chk("rdB8.value", rvb8, e.val);
            if (qb6.size() > 0) begin
                e = qb6.pop_front();
                chk("rdB6.valid", 64'(rvlb6), 64'(e.valid));
                chk("rdB6.err",   64'(reb6),  64'(e.err));
                chk("rdB6.value", rvb6, e.val);
            end
        end
        pend_a = 1'b0; pend_b = 1'b0;
        rd_en_a = 1'b0; rd_en_b = 1'b0; wr_en = 1'b0; clear_req = 1'b0;
        exp_werr8 = 1'b0; exp_werr6 = 1'b0;
    endtask

    task automatic sweep_check(input string name);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk(name, 64'(busy8), 64'(k < 8));
        end
    endtask

    initial begin
        rst_n = 1'b0; clear_req = 1'b0; wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
        wr_tag = '0; rd_tag_a = '0; rd_tag_b = '0; wr_mask = '0; wr_value = '0;
        run8 = 1'b0; run6 = 1'b0; chk6 = 1'b1; pend_a = 1'b0; pend_b = 1'b0;
        exp_werr8 = 1'b0; exp_werr6 = 1'b0;
        for (int i = 0; i < 8; i++) m8[i] = DEFS;
        for (int i = 0; i < 6; i++) m6[i] = DEFS;

        tick(); tick();
        chk("rst.busy8",  64'(busy8), 64'd1);
        chk("rst.busy6",  64'(busy6), 64'd1);
        chk("rst.rva8",   rva8, 64'd0);
        chk("rst.rvla8",  64'(rvla8), 64'd0);
        chk("rst.rea8",   64'(rea8), 64'd0);
        chk("rst.rvb8",   rvb8, 64'd0);

        // Release reset between edges and time both sweeps.
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("sweep.busy8", 64'(busy8), 64'(k < 8));
            chk("sweep.busy6", 64'(busy6), 64'(k < 6));
        end
        run8 = 1'b1; run6 = 1'b1;

        rd_a(3'd5); rd_b(3'd5); tick();
        chk("tag5.literal", rva8, 64'h0005_0033_BF00_0800);

        // Out-of-range on the 6-entry instance.
        wr(3'd7, 4'hF, 64'hDEAD_BEEF_0123_4567); rd_a(3'd6); tick();
        tick();
        for (int t = 0; t < 6; t += 2) begin
            rd_a(3'(t)); rd_b(3'(t + 1)); tick();
        end
        chk6 = 1'b0;

        wr(3'd2, 4'hF, 64'h0010_0020_C000_0200); tick();
        rd_a(3'd2); rd_b(3'd3); tick();
        chk("tag2.literal", rva8, 64'h0010_0020_C000_0200);

        wr(3'd4, 4'b0101, 64'h1111_2222_3333_4444); rd_a(3'd4); rd_b(3'd4); tick();
        chk("bypass.literal", rva8, 64'h0005_2222_BF00_4444);

        wr(3'd3, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF); rd_a(3'd3); tick();
        rd_b(3'd3); tick();

        // Clear concurrent with a write.
        wr(3'd1, 4'hF, 64'hAAAA_BBBB_CCCC_DDDD); tick();
        clear_req = 1'b1; wr(3'd0, 4'hF, 64'h1234_5678_9ABC_DEF0); rd_a(3'd1); tick();
        run8 = 1'b0;
        chk("clr.busy8", 64'(busy8), 64'd1);
        for (int k = 1; k <= 8; k++) begin
            rd_a(3'(k - 1));
            if (k == 3) wr(3'd5, 4'hF, 64'h5555_5555_5555_5555);
            tick();
            chk("clr.sweep.busy8", 64'(busy8), 64'(k < 8));
        end
        run8 = 1'b1;
        for (int i = 0; i < 8; i++) m8[i] = DEFS;
        rd_a(3'd0); rd_b(3'd1); tick();

        // Asynchronous reset in the middle of a sweep.
        wr(3'd2, 4'hF, 64'h0010_0020_C000_0200); tick();
        clear_req = 1'b1; rd_a(3'd2); tick();
        run8 = 1'b0;
        tick();
        wr(3'd6, 4'hF, 64'h0); tick();
        chk("hold.value", rva8, 64'h0010_0020_C000_0200);
        chk("hold.valid", 64'(rvla8), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.rva8",  rva8, 64'd0);
        chk("arst.werr8", 64'(werr8), 64'd0);
        chk("arst.busy8", 64'(busy8), 64'd1);
        chk("arst.rvb8",  rvb8, 64'd0);
        tick(); tick();
        #2 rst_n = 1'b1;
        sweep_check("arst.sweep.busy8");
        run8 = 1'b1;
        for (int i = 0; i < 8; i++) m8[i] = DEFS;
        rd_a(3'd2); rd_b(3'd7); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/neuron_param_store.md
Name: neuron_param_store

Overview:
Parametrised storage for the Izhikevich constants (a, b, c, d) of every neuron in the graph accelerator. It adds the following to the original single-port constant register:
- two independent registered read ports, one per update-pipeline lane;
- per-field write masking;
- same-cycle write-to-read bypass;
- out-of-range tag detection;
- a hardware initialisation sweep that loads default regular-spiking constants into every entry after reset or on request.

It sits between the host-programming interface (write side) and the neuron update pipeline (read side).

Parameters:
- NUMWIDTH, 16: width of each signed two's-complement field, Q8.8 fixed point at default.
- NUMNEURONS, 8: number of neuron entries; need not be a power of two.
- TAGBITS, 3: tag width; must satisfy 2**TAGBITS >= NUMNEURONS.
- DEF_A, 16'h0005: default a (0.02).
- DEF_B, 16'h0033: default b (0.2).
- DEF_C, 16'hBF00: default c (-65).
- DEF_D, 16'h0800: default d (8).

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst_n, input, 1: asynchronous active-low reset.
- clear_req, input, 1: pulse; restarts the init sweep.
- init_busy, output, 1: high while the sweep runs.
- wr_en, input, 1: write strobe.
- wr_tag, input, TAGBITS: entry to write.
- wr_mask, input, 4: field enables {a,b,c,d}; bit3 = a.
- wr_value, input, 4*NUMWIDTH: packed {a,b,c,d}; a occupies the MSBs.
- wr_err, output, 1: registered; high one cycle after a write is rejected.
- rd_en_a, input, 1: read strobe, port A.
- rd_tag_a, input, TAGBITS: read address, port A.
- rd_value_a, output, 4*NUMWIDTH: registered read data, port A.
- rd_valid_a, output, 1: port A data valid.
- rd_err_a, output, 1: port A tag out of range.
- rd_en_b, rd_tag_b, rd_value_b, rd_valid_b, rd_err_b: identical to port A, for port B.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to INIT with sweep pointer = 0 and init_busy = 1.
  - All rd_value = 0; all rd_valid, rd_err and wr_err = 0.
  - Memory contents are undefined until the sweep completes.
- FSM states are INIT and RUN.
- INIT:
  - Each cycle writes {DEF_A,DEF_B,DEF_C,DEF_D} to entry[ptr], then increments ptr.
  - After entry NUMNEURONS-1 is written, go to RUN next cycle and drop init_busy. The sweep therefore takes exactly NUMNEURONS cycles after reset release.
  - Host writes during INIT are discarded and assert wr_err.
  - Reads during INIT produce rd_valid = 0 and rd_value = 0.
- RUN:
  - clear_req returns the FSM to INIT with ptr = 0 on the next edge. Any wr_en in that same cycle is discarded and flagged with wr_err.
  - clear_req while already in INIT restarts the sweep at ptr = 0.
- Write (RUN, wr_en = 1, wr_tag < NUMNEURONS):
  - Each field i with wr_mask[i] = 1 is updated.
  - Fields with a mask bit of 0 are unchanged.
  - wr_mask = 0 is a legal no-op and does not assert wr_err.
- Write with wr_tag >= NUMNEURONS: ignored; wr_err = 1 the next cycle.
- Read: 1-cycle latency.
  - rd_en_x at edge N gives rd_value_x, rd_valid_x = 1 and rd_err_x after edge N.
  - When rd_en_x = 0, rd_valid_x = 0 and rd_value_x holds its last value.
- Out-of-range read tag: rd_valid_x = 1, rd_err_x = 1, rd_value_x = 0.
- Bypass: if a RUN write hits the same in-range tag as a read in the same cycle, the read returns the post-write entry, with masked fields merged. Bypass applies to both ports independently.
- Ports A and B may read the same tag in the same cycle; both return identical data.
- No backpressure: read requests are accepted every cycle.

Test Plan:
- Release rst_n with NUMNEURONS = 8:
  - init_busy stays high for exactly 8 cycles, then drops.
  - A subsequent read of tag 5 returns 64'h0005_0033_BF00_0800 with rd_valid = 1 one cycle later.
- Write tag 2 with value 64'h0010_0020_C000_0200 and mask 4'b1111, then read tag 2 on port A and tag 3 on port B:
  - Port A returns the written value.
  - Port B returns the defaults.
- Write tag 4 with mask 4'b0101 and value 64'h1111_2222_3333_4444, reading tag 4 on port A in the same cycle:
  - Port A returns 64'h0005_2222_BF00_4444 (bypass plus mask merge).
- With NUMNEURONS = 6, write tag 7 and read tag 6:
  - wr_err pulses once.
  - rd_err_a = 1 with rd_value_a = 0.
  - Entries 0-5 are unchanged.
- Program tag 1, then pulse clear_req concurrently with a write to tag 0:
  - wr_err = 1.
  - init_busy is high for 8 cycles.
  - Reads during the sweep give rd_valid = 0.
  - Tags 0 and 1 read back as defaults afterwards.
- Assert rst_n low asynchronously mid-sweep (between clock edges):
  - Outputs clear immediately.
  - The sweep restarts from 0 after release and again takes exactly 8 cycles.
